// File: rtl/spi_mnrch_16.sv
// spi_mnrch_16: 16-bit SPI master, mode 3, for the inertial sensor link.
// One wrt launches one full-duplex frame; rsp/done hold until the next wrt.
module spi_mnrch_16 #(
  parameter int DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rsp,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRONT = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] BACK  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_IDLE =
    {2'b10, {(DIV_W-2){1'b1}}};
  localparam logic [DIV_W-1:0] DIV_RISE =
    {1'b0, {(DIV_W-1){1'b1}}};
  localparam logic [DIV_W-1:0] DIV_FALL = '1;

  logic [1:0]       state;
  logic [DIV_W-1:0] sclk_div;
  logic [15:0]      shft_reg;
  logic [4:0]       bit_cnt;
  logic             smpl;
  logic             rise_imm;
  logic             fall_imm;

  assign rise_imm = (sclk_div == DIV_RISE);
  assign fall_imm = (sclk_div == DIV_FALL);

  assign SCLK = sclk_div[DIV_W-1];
  assign MOSI = shft_reg[15];
  assign rsp  = shft_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sclk_div <= DIV_IDLE;
      shft_reg <= '0;
      bit_cnt  <= '0;
      smpl     <= 1'b0;
      done     <= 1'b0;
      SS_n     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          sclk_div <= DIV_IDLE;
          if (wrt) begin
            shft_reg <= cmd;
            done     <= 1'b0;
            bit_cnt  <= '0;
            SS_n     <= 1'b0;
            sclk_div <= DIV_IDLE + 1'b1;
            state    <= FRONT;
          end
        end
        FRONT: begin
          sclk_div <= sclk_div + 1'b1;
          if (fall_imm)
            state <= SHIFT;
        end
        SHIFT: begin
          sclk_div <= sclk_div + 1'b1;
          if (rise_imm) begin
            smpl <= MISO;
            if (bit_cnt == 5'd15)
              state <= BACK;
          end
          if (fall_imm) begin
            shft_reg <= {shft_reg[14:0], smpl};
            bit_cnt  <= bit_cnt + 5'd1;
          end
        end
        BACK: begin
          // Final shift ends the frame with SCLK parked high.
          if (fall_imm) begin
            shft_reg <= {shft_reg[14:0], smpl};
            bit_cnt  <= bit_cnt + 5'd1;
            SS_n     <= 1'b1;
            done     <= 1'b1;
            sclk_div <= DIV_IDLE;
            state    <= IDLE;
          end else begin
            sclk_div <= sclk_div + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mnrch_16.sv
// tb_spi_mnrch_16: scoreboard bench for spi_mnrch_16.
// Loopback and a small sensor model drive MISO.
module tb_spi_mnrch_16;

  logic        clk;
  logic        rst;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rsp;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  logic        sel_nemo;
  logic [15:0] s_tx;
  logic [15:0] s_rx;
  int          s_n;
  logic [7:0]  s_regs [128];

  int checks;
  int fails;
  logic [15:0] sb[$];

  spi_mnrch_16 dut (
    .clk  (clk),
    .rst  (rst),
    .wrt  (wrt),
    .cmd  (cmd),
    .done (done),
    .rsp  (rsp),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MISO = sel_nemo ? s_tx[15] : MOSI;

  // Sensor: reply byte appears after the 8 address bits
  always @(negedge SS_n) begin
    s_tx = 16'h0000;
    s_n  = 0;
  end

  always @(posedge SCLK) begin
    if (!SS_n) begin
      s_rx = {s_rx[14:0], MOSI};
      s_n++;
      s_tx = s_tx << 1;
      if (s_n == 8 && s_rx[7])
        s_tx[15:8] = s_regs[s_rx[6:0]];
      if (s_n == 16 && !s_rx[15])
        s_regs[s_rx[14:8]] = s_rx[7:0];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic [15:0] c,
                       input logic [15:0] e,
                       input int inj,
                       output int lat,
                       output int lowc,
                       output int ffall,
                       output int nf,
                       output int nr,
                       output logic [15:0] mbits,
                       output logic stab);
    logic ps;
    logic pm;
    logic [15:0] got;
    @(negedge clk);
    cmd = c;
    wrt = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    wrt = 1'b0;
    cmd = 16'h5A5A;
    chk("done_clr", {31'd0, done}, 32'd0);
    lat = 0; lowc = 0; ffall = 0; nf = 0; nr = 0;
    mbits = '0; stab = 1'b1;
    ps = SCLK; pm = MOSI;
    while (!done && lat < 700) begin
      if (lat == inj) begin
        wrt = 1'b1;
        cmd = 16'hFFFF;
      end
      if (!SS_n) lowc++;
      @(posedge clk);
      #1;
      lat++;
      wrt = 1'b0;
      if (ps && !SCLK) begin
        nf++;
        if (ffall == 0) ffall = lat;
      end
      if (!ps && SCLK) begin
        nr++;
        mbits = {mbits[14:0], pm};
      end
      if (MOSI != pm && !(ps && !SCLK)) stab = 1'b0;
      ps = SCLK;
      pm = MOSI;
    end
    if (done && sb.size() > 0) begin
      got = sb.pop_front();
      chk("rsp", {16'd0, rsp}, {16'd0, got});
    end else begin
      chk("done_seen", {31'd0, done}, 32'd1);
    end
  endtask

  int lat, lowc, ff, nf, nr;
  logic [15:0] mb;
  logic st;
  int lowseen;

  initial begin
    checks = 0;
    fails = 0;
    rst = 1'b1;
    wrt = 1'b0;
    cmd = 16'h0000;
    sel_nemo = 1'b0;
    s_tx = '0;
    s_rx = '0;
    s_n = 0;
    for (int i = 0; i < 128; i++) s_regs[i] = 8'h00;
    s_regs[7'h0F] = 8'h6A;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ssn", {31'd0, SS_n}, 32'd1);
    chk("rst_sclk", {31'd0, SCLK}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rsp", {16'd0, rsp}, 32'd0);
    chk("rst_mosi", {31'd0, MOSI}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    frame(16'hA5C3, 16'hA5C3, -1, lat, lowc, ff, nf, nr, mb, st);
    chk("lat", lat, 520);
    chk("ssn_low", lowc, 520);
    chk("front", ff, 8);
    chk("falls", nf, 16);
    chk("rises", nr, 16);
    chk("mosi_seq", {16'd0, mb}, 32'h0000A5C3);
    chk("mosi_stab", {31'd0, st}, 32'd1);
    chk("sclk_end", {31'd0, SCLK}, 32'd1);
    chk("ssn_end", {31'd0, SS_n}, 32'd1);

    sel_nemo = 1'b1;
    frame(16'h8F00, 16'h006A, -1, lat, lowc, ff, nf, nr, mb, st);
    chk("whoami_lat", lat, 520);
    frame(16'h0D02, 16'h0000, -1, lat, lowc, ff, nf, nr, mb, st);
    chk("int_cfg_done", {31'd0, done}, 32'd1);
    chk("int_cfg_reg", {24'd0, s_regs[7'h0D]}, 32'h02);
    sel_nemo = 1'b0;

    frame(16'h3C96, 16'h3C96, 200, lat, lowc, ff, nf, nr, mb, st);
    chk("ign_lat", lat, 520);
    chk("ign_falls", nf, 16);
    lowseen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (!SS_n) lowseen++;
    end
    chk("ign_no_frame", lowseen, 0);
    chk("ign_done_hold", {31'd0, done}, 32'd1);
    chk("ign_rsp_hold", {16'd0, rsp}, 32'h3C96);

    @(negedge clk);
    cmd = 16'h0F0F;
    wrt = 1'b1;
    @(posedge clk);
    #1;
    wrt = 1'b0;
    repeat (299) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ssn", {31'd0, SS_n}, 32'd1);
    chk("abort_sclk", {31'd0, SCLK}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_rsp", {16'd0, rsp}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", {31'd0, done}, 32'd0);

    frame(16'h1234, 16'h1234, -1, lat, lowc, ff, nf, nr, mb, st);
    chk("post_rst_lat", lat, 520);

    frame(16'h00FF, 16'h00FF, -1, lat, lowc, ff, nf, nr, mb, st);
    chk("b2b_lat", lat, 520);
    chk("b2b_mosi", {16'd0, mb}, 32'h000000FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
